// File: rtl/seq_divider_if.sv
// Request/response bundle for seq_divider: start with operands in,
// busy/done/err with quotient and remainder out.
interface seq_divider_if #(
    parameter int WIDTH = 18
);
    logic                 start;
    logic [2*WIDTH-1:0]   dividend;
    logic [WIDTH-1:0]     divisor;
    logic                 busy;
    logic                 done;
    logic                 err;
    logic [WIDTH-1:0]     quotient;
    logic [WIDTH-1:0]     remainder;

    modport master (
        output start, dividend, divisor,
        input  busy, done, err, quotient, remainder
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, err, quotient, remainder
    );
endinterface

// File: rtl/seq_divider.sv
// Restoring divider, 2*WIDTH / WIDTH -> WIDTH quotient and remainder, one bit per clock.
// Optional round-to-nearest of the quotient under SEQ_DIVIDER_ROUND_EN.
module seq_divider #(
    parameter int WIDTH = 18
) (
    input  logic        CLK,
    input  logic        RST,
    seq_divider_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);

    // FIN is the cycle between the last step and the done pulse; it forms the result.
    typedef enum logic [1:0] {IDLE, RUN, FIN, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] p_q, p_d;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic [WIDTH-1:0] div_q, div_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             fault_q, fault_d;
    logic             err_q, err_d;
    logic [WIDTH:0]   trial;
    logic             fit;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            p_q     <= '0;
            sh_q    <= '0;
            div_q   <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            cnt_q   <= '0;
            fault_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            p_q     <= p_d;
            sh_q    <= sh_d;
            div_q   <= div_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
            fault_q <= fault_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        p_d     = p_q;
        sh_d    = sh_q;
        div_d   = div_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        cnt_d   = cnt_q;
        fault_d = fault_q;
        err_d   = err_q;
        trial   = {p_q, sh_q[WIDTH-1]};
        fit     = trial >= {1'b0, div_q};

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    p_d     = bus.dividend[2*WIDTH-1:WIDTH];
                    sh_d    = bus.dividend[WIDTH-1:0];
                    div_d   = bus.divisor;
                    cnt_d   = '0;
                    fault_d = (bus.divisor == '0) ||
                              (bus.dividend[2*WIDTH-1:WIDTH] >= bus.divisor);
                    state_d = fault_d ? FIN : RUN;
                end
            end
            RUN: begin
                // Quotient bits shift in behind the dividend bits being consumed.
                p_d   = fit ? (trial[WIDTH-1:0] - div_q) : trial[WIDTH-1:0];
                sh_d  = {sh_q[WIDTH-2:0], fit};
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = FIN;
                end
            end
            FIN: begin
                state_d = DONE;
                if (fault_q) begin
                    quot_d = '1;
                    rem_d  = '0;
                    err_d  = 1'b1;
                end else begin
                    quot_d = sh_q;
                    rem_d  = p_q;
                    err_d  = 1'b0;
`ifdef SEQ_DIVIDER_ROUND_EN
                    if ({p_q, 1'b0} >= {1'b0, div_q}) begin
                        if (&sh_q) begin
                            err_d = 1'b1;
                        end else begin
                            quot_d = sh_q + WIDTH'(1);
                        end
                    end
`endif
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.busy      = (state_q != IDLE);
    assign bus.done      = (state_q == DONE);
    assign bus.err       = err_q;
    assign bus.quotient  = quot_q;
    assign bus.remainder = rem_q;
endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: vector table, handshake corner cases,
// and random operands against an arithmetic reference through a result scoreboard.
module tb_seq_divider;
    localparam int W = 18;

    typedef struct {
        logic [2*W-1:0] dd;
        logic [W-1:0]   dv;
        logic [W-1:0]   q;
        logic [W-1:0]   r;
        logic           err;
        int             lat;
    } vec_t;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         err;
    } exp_t;

    logic   clk;
    logic   rst;
    exp_t   sb[$];
    int     n_checks;
    int     n_fail;
    logic   prev_done;
    vec_t   vecs[8];

    seq_divider_if #(.WIDTH(W)) bus ();

    seq_divider #(.WIDTH(W)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t round_adj(input exp_t e, input logic [W-1:0] dv);
        exp_t o;
        o = e;
`ifdef SEQ_DIVIDER_ROUND_EN
        if (!e.err && ({1'b0, e.r} * 2 >= {1'b0, dv})) begin
            if (e.q == {W{1'b1}}) o.err = 1'b1;
            else o.q = e.q + 1'b1;
        end
`endif
        return o;
    endfunction

    function automatic exp_t model(input logic [2*W-1:0] dd, input logic [W-1:0] dv);
        exp_t e;
        logic [2*W-1:0] qq;
        logic [2*W-1:0] rr;
        if (dv == 0 || dd[2*W-1:W] >= dv) begin
            e.q = {W{1'b1}};
            e.r = '0;
            e.err = 1'b1;
        end else begin
            qq = dd / {{W{1'b0}}, dv};
            rr = dd % {{W{1'b0}}, dv};
            e.q = qq[W-1:0];
            e.r = rr[W-1:0];
            e.err = 1'b0;
        end
        return round_adj(e, dv);
    endfunction

    // Every cycle advance: sample after the edge, check done pulse shape and scoreboard.
    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        if (bus.done) begin
            chk("done_single_pulse", {63'd0, prev_done}, 64'd0);
            if (sb.size() == 0) begin
                chk("unexpected_done", 64'd1, 64'd0);
            end else begin
                e = sb.pop_front();
                chk("quotient", {46'd0, bus.quotient}, {46'd0, e.q});
                chk("remainder", {46'd0, bus.remainder}, {46'd0, e.r});
                chk("err", {63'd0, bus.err}, {63'd0, e.err});
            end
        end
        prev_done = bus.done;
    endtask

    task automatic wait_done(inout int n, input int lat, input string name);
        while (!bus.done && n < 100) begin
            tick();
            n++;
            if (!bus.done) chk({name, "_busy_run"}, {63'd0, bus.busy}, 64'd1);
        end
        chk({name, "_latency"}, 64'(n), 64'(lat));
        chk({name, "_busy_in_done"}, {63'd0, bus.busy}, 64'd1);
    endtask

    task automatic run_job(input logic [2*W-1:0] dd, input logic [W-1:0] dv,
                           input exp_t e, input int lat, input string name);
        int n;
        bus.start    = 1'b1;
        bus.dividend = dd;
        bus.divisor  = dv;
        sb.push_back(e);
        tick();
        bus.start    = 1'b0;
        bus.dividend = {$urandom, $urandom};
        bus.divisor  = W'($urandom);
        chk({name, "_busy_accept"}, {63'd0, bus.busy}, 64'd1);
        chk({name, "_no_done_accept"}, {63'd0, bus.done}, 64'd0);
        n = 0;
        wait_done(n, lat, name);
        tick();
        chk({name, "_busy_after"}, {63'd0, bus.busy}, 64'd0);
    endtask

    initial begin
        exp_t e;
        int n;
        logic [W-1:0] hi, lo, dv;
        n_checks  = 0;
        n_fail    = 0;
        prev_done = 1'b0;
        rst          = 1'b1;
        bus.start    = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;

        vecs[0] = '{36'd100, 18'd7, 18'd14, 18'd2, 1'b0, W + 1};
        vecs[1] = '{36'h3FFFFFFFF, 18'h3FFFF, 18'h10000, 18'h0FFFF, 1'b0, W + 1};
        vecs[2] = '{36'd5, 18'd0, 18'h3FFFF, 18'd0, 1'b1, 1};
        vecs[3] = '{36'hFFFFFFFFF, 18'd1, 18'h3FFFF, 18'd0, 1'b1, 1};
        vecs[4] = '{36'd0, 18'd5, 18'd0, 18'd0, 1'b0, W + 1};
        vecs[5] = '{{18'h3FFFE, 18'h3FFFF}, 18'h3FFFF, 18'h3FFFF, 18'h3FFFE, 1'b0, W + 1};
        vecs[6] = '{{18'd7, 18'd0}, 18'd7, 18'h3FFFF, 18'd0, 1'b1, 1};
        vecs[7] = '{36'd11, 18'd2, 18'd5, 18'd1, 1'b0, W + 1};

        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", {63'd0, bus.busy}, 64'd0);
        chk("rst_done", {63'd0, bus.done}, 64'd0);
        chk("rst_err", {63'd0, bus.err}, 64'd0);
        chk("rst_quotient", {46'd0, bus.quotient}, 64'd0);
        chk("rst_remainder", {46'd0, bus.remainder}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 8; i++) begin
            e.q = vecs[i].q;
            e.r = vecs[i].r;
            e.err = vecs[i].err;
            run_job(vecs[i].dd, vecs[i].dv, round_adj(e, vecs[i].dv), vecs[i].lat,
                    $sformatf("vec%0d", i));
        end

        // start re-pulsed mid-run with other operands must be ignored
        bus.start = 1'b1; bus.dividend = 36'd100; bus.divisor = 18'd7;
        e.q = 18'd14; e.r = 18'd2; e.err = 1'b0;
        sb.push_back(round_adj(e, 18'd7));
        tick();
        bus.start = 1'b0;
        n = 0;
        repeat (4) begin tick(); n++; end
        bus.start = 1'b1; bus.dividend = 36'd11; bus.divisor = 18'd2;
        tick(); n++;
        bus.start = 1'b0;
        wait_done(n, W + 1, "repulse");
        repeat (25) tick();
        chk("repulse_sb_empty", 64'(sb.size()), 64'd0);

        // asynchronous reset in RUN cycle 9 aborts the job
        bus.start = 1'b1; bus.dividend = 36'd100; bus.divisor = 18'd7;
        sb.push_back(round_adj(e, 18'd7));
        tick();
        bus.start = 1'b0;
        repeat (9) tick();
        rst = 1'b1;
        #1;
        chk("midrst_busy", {63'd0, bus.busy}, 64'd0);
        chk("midrst_done", {63'd0, bus.done}, 64'd0);
        chk("midrst_quotient", {46'd0, bus.quotient}, 64'd0);
        chk("midrst_remainder", {46'd0, bus.remainder}, 64'd0);
        sb.delete();
        prev_done = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        tick();
        e.q = 18'd5; e.r = 18'd1; e.err = 1'b0;
        run_job(36'd11, 18'd2, round_adj(e, 18'd2), W + 1, "after_rst");

        // start held high: one idle cycle between jobs
        bus.start = 1'b1; bus.dividend = 36'd100; bus.divisor = 18'd7;
        e = model(36'd100, 18'd7);
        sb.push_back(e);
        sb.push_back(e);
        tick();
        n = 0;
        wait_done(n, W + 1, "held1");
        tick();
        chk("held_idle_gap", {63'd0, bus.busy}, 64'd0);
        tick();
        chk("held_reaccept", {63'd0, bus.busy}, 64'd1);
        chk("held_no_done_accept", {63'd0, bus.done}, 64'd0);
        bus.start = 1'b0;
        n = 0;
        wait_done(n, W + 1, "held2");
        tick();
        chk("held_busy_after", {63'd0, bus.busy}, 64'd0);

        for (int i = 0; i < 1000; i++) begin
            dv = W'($urandom_range(1, (1 << W) - 1));
            hi = W'($urandom % {14'd0, dv});
            lo = W'($urandom);
            run_job({hi, lo}, dv, model({hi, lo}, dv), W + 1, "rand");
        end

        chk("final_sb_empty", 64'(sb.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
- Sequential restoring divider for the fixed-point datapath; the inverse of the iterative shift-add multiplier.
- Divides a 2*WIDTH-bit unsigned dividend by a WIDTH-bit unsigned divisor, one quotient bit per clock.
- Produces a WIDTH-bit quotient and remainder, rescaling multiplier products back to WIDTH-bit operands.
- Start/busy/done handshake for use by the map iteration controller.

Parameters:
- WIDTH, 18, divisor/quotient/remainder width; dividend is 2*WIDTH bits.

Ports:
- CLK  input  1  clock, rising-edge active.
- RST  input  1  reset, asynchronous, active-high.
- start  input  1  request; sampled only in IDLE.
- dividend  input  2*WIDTH  unsigned dividend; sampled on the accepting edge.
- divisor  input  WIDTH  unsigned divisor; sampled on the accepting edge.
- busy  output  1  high while a division is in progress (RUN or DONE).
- done  output  1  one-cycle pulse when results are valid.
- err  output  1  divide-by-zero or quotient overflow; valid with done, held until next accept.
- quotient  output  WIDTH  result quotient; held until next accept.
- remainder  output  WIDTH  result remainder; held until next accept.

Behaviour:
- Reset, asynchronous, any state: state=IDLE; busy, done, err, quotient, remainder = 0; internal registers cleared.
- Reset mid-operation aborts the division. No done is issued.
- States:
  - IDLE: start=1 latches dividend/divisor, evaluates errors, and sets busy=1.
    - Divisor==0 -> DONE.
    - dividend[2W-1:W] >= divisor (quotient would exceed WIDTH bits) -> DONE.
    - Otherwise -> RUN with count=0.
  - RUN: one restoring step per cycle.
    - Partial remainder P (WIDTH+1 bits) = {P, next dividend bit, MSB first}.
    - If P >= divisor: subtract and shift 1 into quotient; else shift 0.
    - After exactly WIDTH steps -> DONE.
  - DONE: output registers updated and done=1 for exactly one cycle, then -> IDLE with busy=0 on the following edge.
- Initial partial remainder = dividend[2W-1:W]. Low WIDTH dividend bits are consumed MSB first.
- Latency, normal case: start sampled at edge 0; done high during the cycle after edge WIDTH+1 (WIDTH=18: 19th edge after accept). busy high for WIDTH+2 cycles total.
- Latency, error case: done on the edge after accept; busy high for 2 cycles.
- Error result: err=1, quotient = all ones (saturated), remainder=0.
- Normal result: err=0, quotient*divisor + remainder == dividend, remainder < divisor.
- start while busy=1 is ignored; inputs are not re-sampled.
- start held high continuously: a new division is accepted in the IDLE cycle after DONE, i.e. one idle cycle between jobs.
- Outputs change only in DONE or on reset. done never asserts in the same cycle as start is accepted.

Optional Feature:
- Macro: SEQ_DIVIDER_ROUND_EN.
- Defined: in DONE (non-error case), quotient is rounded to nearest, half up. If 2*remainder >= divisor, quotient+1, saturating at all ones with err=1 on saturation. remainder output remains the truncated remainder. Latency unchanged.
- Undefined: quotient is truncated (floor). No extra comparator or adder is synthesized.

Test Plan:
- Basic: dividend=100, divisor=7, start pulse -> done after 19 cycles (WIDTH=18), quotient=14, remainder=2, err=0; busy high from accept through done cycle.
- Wide: dividend=2^34-1, divisor=0x3FFFF -> quotient=0x10000, remainder=0xFFFF, err=0.
- Errors:
  - dividend=5, divisor=0 -> done on next cycle, err=1, quotient=0x3FFFF, remainder=0.
  - dividend=2^36-1, divisor=1 -> same overflow response.
- Reset mid-op: start 100/7, assert RST at RUN cycle 9 -> immediately busy=0, done=0, quotient=0. After release, start 11/2 completes normally: quotient=5, remainder=1 (quotient=6 with SEQ_DIVIDER_ROUND_EN).
- Handshake: start re-pulsed with different operands during RUN -> ignored, first result unchanged. start held high -> back-to-back jobs with exactly one idle cycle between done and next busy.
- Random: 1000 random nonzero-divisor, non-overflow operand pairs checked against a reference model. Assert done is always a single-cycle pulse.
